// File: rtl/act_seq_pkg.sv
// -----------------------------------------------------------------------------
// act_seq_pkg
//
// Shared definitions for the actuator sequencer:
//   - FSM state encoding (also reported in the STATUS register)
//   - register byte offsets on the CPU bus
//   - STATUS register bit positions
//   - helpers mapping a state to its valve / pump drive levels
//
// Optional feature macro used by the files importing this package:
//   ACT_SEQ_WATCHDOG_EN - enables MAXON, the FAULT state and the fault clear.
// -----------------------------------------------------------------------------
package act_seq_pkg;

    // FSM state encoding. The values are visible to software through STATUS,
    // so they must not be renumbered.
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_VALVE    = 3'd1;
    localparam logic [2:0] ST_OPENING  = 3'd2;
    localparam logic [2:0] ST_RUNNING  = 3'd3;
    localparam logic [2:0] ST_STOPPING = 3'd4;
    localparam logic [2:0] ST_FAULT    = 3'd5;

    // Register byte offsets.
    localparam logic [4:0] ADDR_STATUS = 5'h00;
    localparam logic [4:0] ADDR_SETTLE = 5'h04;
    localparam logic [4:0] ADDR_DRAIN  = 5'h08;
    localparam logic [4:0] ADDR_MAXON  = 5'h0C;
    localparam logic [4:0] ADDR_CTRL   = 5'h10;

    // STATUS = {26'b0, fault, state[2:0], pump_en, valve_en}
    localparam int STATUS_VALVE_BIT = 0;
    localparam int STATUS_PUMP_BIT  = 1;
    localparam int STATUS_STATE_LSB = 2;
    localparam int STATUS_STATE_MSB = 4;
    localparam int STATUS_FAULT_BIT = 5;

    // The valve is held open in every state that may have water under
    // pressure, i.e. everything except IDLE and FAULT.
    function automatic logic valve_on(input logic [2:0] st);
        return (st == ST_VALVE)   || (st == ST_OPENING) ||
               (st == ST_RUNNING) || (st == ST_STOPPING);
    endfunction

    // The pump only runs in RUNNING; OPENING and STOPPING bracket it so the
    // valve is always open around any pump activity.
    function automatic logic pump_on(input logic [2:0] st);
        return (st == ST_RUNNING);
    endfunction

endpackage

// File: rtl/actuator_sequencer_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
//
// Free-running prescaler producing a one-clk tick every PRESCALE cycles.
// The counter runs 0..PRESCALE-1 and the tick is high while it sits at
// PRESCALE-1, so ticks are evenly spaced from reset release onwards.
//
// Parameters:
//   PRESCALE - clk cycles per tick, must be >= 2
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous active-low reset
//   tick out  one-cycle pulse every PRESCALE clocks
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int PRESCALE = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int          W    = $clog2(PRESCALE);
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] div_q;
    logic [W-1:0] div_d;

    assign tick = (div_q == LAST);

    always_comb begin
        div_d = div_q + W'(1);
        if (tick) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/actuator_sequencer.sv
// -----------------------------------------------------------------------------
// actuator_sequencer
//
// Sequences the irrigation valve and pump from the 2-bit GPIO command word
// (cmd[0] = valve request, cmd[1] = pump request) so that the valve is open
// before the pump starts and the pump is stopped before the valve closes.
// Settle / drain / max-on times are programmable over the CPU bus in units
// of prescaled ticks.
//
// Optional feature (macro ACT_SEQ_WATCHDOG_EN):
//   defined     - MAXON register, FAULT state, sticky fault output and the
//                 CTRL fault clear are present.
//   not defined - MAXON reads 0 and ignores writes, FAULT is unreachable,
//                 fault is tied 0 and CTRL writes are ignored.
//
// Parameters:
//   PRESCALE   - clk cycles per timer tick (>= 2)
//   CNT_W      - width of timer registers and the state counter (<= 32)
//   SETTLE_DEF - reset value of SETTLE (ticks)
//   DRAIN_DEF  - reset value of DRAIN (ticks)
//   MAXON_DEF  - reset value of MAXON (ticks, 0 = unlimited)
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   addr[4:0]  in   register byte address
//   cs/rd/wr   in   chip select, read strobe, write strobe (write = cs & wr)
//   d_in[31:0] in   write data
//   d_out[31:0] out read data, combinational from addr
//   mem_ready  out  always 1 (zero wait states)
//   cmd[1:0]   in   GPIO command, same clock domain
//   valve_en   out  valve drive, registered
//   pump_en    out  pump drive, registered
//   fault      out  sticky watchdog fault, registered
//
// Bus handshake: there is no valid/ready pairing here; a write is accepted
// on every clk edge where cs & wr is high, and reads are purely
// combinational from addr, which is why mem_ready is constant 1.
//
// Register map:
//   0x00 STATUS (RO)  {26'b0, fault, state[2:0], pump_en, valve_en}
//   0x04 SETTLE (RW)  ticks the valve is open before the pump starts
//   0x08 DRAIN  (RW)  ticks the valve stays open after the pump stops
//   0x0C MAXON  (RW)  pump run-time limit, 0 = unlimited
//   0x10 CTRL   (WO)  bit 0 = fault clear; reads 0
// -----------------------------------------------------------------------------
module actuator_sequencer
    import act_seq_pkg::*;
#(
    parameter int PRESCALE   = 50000,
    parameter int CNT_W      = 16,
    parameter int SETTLE_DEF = 2,
    parameter int DRAIN_DEF  = 2,
    parameter int MAXON_DEF  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  addr,
    input  logic        cs,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] d_in,
    output logic [31:0] d_out,
    output logic        mem_ready,
    input  logic [1:0]  cmd,
    output logic        valve_en,
    output logic        pump_en,
    output logic        fault
);

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    logic             tick;
    logic             wr_en;

    logic [2:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [CNT_W-1:0] settle_q, settle_d;
    logic [CNT_W-1:0] drain_q,  drain_d;
    logic             valve_q,  valve_d;
    logic             pump_q,   pump_d;

`ifdef ACT_SEQ_WATCHDOG_EN
    logic [CNT_W-1:0] maxon_q,  maxon_d;
    logic             fault_q,  fault_d;
    logic             clr_req;
`else
    logic [CNT_W-1:0] unused_maxon_def;
`endif

    // rd carries no information for a combinational read port, and only the
    // low CNT_W bits of d_in are ever stored.
    logic             unused_bus;
    assign unused_bus = ^{rd, d_in};

    assign wr_en     = cs & wr;
    assign mem_ready = 1'b1;

    // -------------------------------------------------------------------------
    // Tick prescaler
    // -------------------------------------------------------------------------
    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // -------------------------------------------------------------------------
    // Timer registers
    // -------------------------------------------------------------------------
    always_comb begin
        settle_d = settle_q;
        drain_d  = drain_q;
        if (wr_en && (addr == ADDR_SETTLE)) begin
            settle_d = d_in[CNT_W-1:0];
        end
        if (wr_en && (addr == ADDR_DRAIN)) begin
            drain_d = d_in[CNT_W-1:0];
        end
    end

`ifdef ACT_SEQ_WATCHDOG_EN
    assign clr_req = wr_en && (addr == ADDR_CTRL) && d_in[0];

    always_comb begin
        maxon_d = maxon_q;
        if (wr_en && (addr == ADDR_MAXON)) begin
            maxon_d = d_in[CNT_W-1:0];
        end
    end
`else
    assign unused_maxon_def = CNT_W'(MAXON_DEF);
`endif

    // -------------------------------------------------------------------------
    // Sequencing FSM
    //
    // Timer comparisons use the registered counter, which is zero on the
    // first cycle of every state, so a timer value of 0 exits immediately.
    // A freshly written timer register is therefore seen by the very next
    // comparison.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd[1]) begin
                    state_d = ST_OPENING;
                end else if (cmd[0]) begin
                    state_d = ST_VALVE;
                end
            end
            ST_VALVE: begin
                if (cmd[1]) begin
                    state_d = ST_OPENING;
                end else if (!cmd[0]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_OPENING: begin
                // Losing the pump request wins over settle expiry in the same
                // cycle so the pump never starts without a live request.
                if (!cmd[1]) begin
                    state_d = cmd[0] ? ST_VALVE : ST_IDLE;
                end else if (cnt_q >= settle_q) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
`ifdef ACT_SEQ_WATCHDOG_EN
                // Watchdog first: an overrun is reported even if the pump
                // request happens to drop in the same cycle.
                if ((maxon_q != '0) && (cnt_q >= maxon_q)) begin
                    state_d = ST_FAULT;
                end else if (!cmd[1]) begin
                    state_d = ST_STOPPING;
                end
`else
                if (!cmd[1]) begin
                    state_d = ST_STOPPING;
                end
`endif
            end
            ST_STOPPING: begin
                // cmd is only looked at once the drain time has elapsed.
                if (cnt_q >= drain_q) begin
                    if (cmd[1]) begin
                        state_d = ST_OPENING;
                    end else if (cmd[0]) begin
                        state_d = ST_VALVE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FAULT: begin
`ifdef ACT_SEQ_WATCHDOG_EN
                // Clearing while the pump is still requested would restart it
                // straight away, so the clear needs cmd[1] low.
                if (clr_req && !cmd[1]) begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State counter: zero on entry, +1 per tick, saturating at all-ones so a
    // long stay can never wrap back below a threshold.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (tick && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Drives are decoded from the next state so they switch on the same edge
    // as the state register.
    always_comb begin
        valve_d = valve_on(state_d);
        pump_d  = pump_on(state_d);
    end

`ifdef ACT_SEQ_WATCHDOG_EN
    always_comb begin
        fault_d = (state_d == ST_FAULT);
    end
`endif

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            settle_q <= CNT_W'(SETTLE_DEF);
            drain_q  <= CNT_W'(DRAIN_DEF);
            valve_q  <= 1'b0;
            pump_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            drain_q  <= drain_d;
            valve_q  <= valve_d;
            pump_q   <= pump_d;
        end
    end

`ifdef ACT_SEQ_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            maxon_q <= CNT_W'(MAXON_DEF);
            fault_q <= 1'b0;
        end else begin
            maxon_q <= maxon_d;
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign valve_en = valve_q;
    assign pump_en  = pump_q;

    // -------------------------------------------------------------------------
    // Read mux
    // -------------------------------------------------------------------------
    always_comb begin
        d_out = '0;
        case (addr)
            ADDR_STATUS: begin
                d_out[STATUS_VALVE_BIT]                   = valve_q;
                d_out[STATUS_PUMP_BIT]                    = pump_q;
                d_out[STATUS_STATE_MSB:STATUS_STATE_LSB]  = state_q;
                d_out[STATUS_FAULT_BIT]                   = fault;
            end
            ADDR_SETTLE: begin
                d_out[CNT_W-1:0] = settle_q;
            end
            ADDR_DRAIN: begin
                d_out[CNT_W-1:0] = drain_q;
            end
`ifdef ACT_SEQ_WATCHDOG_EN
            ADDR_MAXON: begin
                d_out[CNT_W-1:0] = maxon_q;
            end
`endif
            default: begin
                d_out = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_actuator_sequencer.sv
// -----------------------------------------------------------------------------
// tb_actuator_sequencer
//
// Bench for actuator_sequencer with PRESCALE=4. A reference model follows
// the sequencing rules (which drive levels each mode implies, how many
// ticks have elapsed in the current mode, register contents) and one
// compare process checks valve_en, pump_en, fault and d_out against it
// after every clock. Directed sections pin the model with literal
// expectations; a randomized section then exercises cmd / bus traffic.
// Build with +define+ACT_SEQ_WATCHDOG_EN to cover the watchdog.
// -----------------------------------------------------------------------------
module tb_actuator_sequencer;

    localparam int PRESCALE = 4;
    localparam int CNT_W    = 16;
`ifdef ACT_SEQ_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    // ---------------------------------------------------------------- clock/reset
    logic        clk  = 1'b0;
    logic        rst  = 1'b0;
    logic [4:0]  addr = '0;
    logic        cs   = 1'b0;
    logic        rd   = 1'b0;
    logic        wr   = 1'b0;
    logic [31:0] d_in = '0;
    logic [1:0]  cmd  = '0;
    logic [31:0] d_out;
    logic        mem_ready;
    logic        valve_en;
    logic        pump_en;
    logic        fault;

    always #5 clk = ~clk;

    actuator_sequencer #(
        .PRESCALE   (PRESCALE),
        .CNT_W      (CNT_W),
        .SETTLE_DEF (2),
        .DRAIN_DEF  (2),
        .MAXON_DEF  (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .cs        (cs),
        .rd        (rd),
        .wr        (wr),
        .d_in      (d_in),
        .d_out     (d_out),
        .mem_ready (mem_ready),
        .cmd       (cmd),
        .valve_en  (valve_en),
        .pump_en   (pump_en),
        .fault     (fault)
    );

    // ---------------------------------------------------------------- scoreboard
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- reference model
    // Modes: 0 idle, 1 valve only, 2 opening, 3 running, 4 stopping, 5 fault.
    int m_mode   = 0;
    int m_ticks  = 0;   // ticks seen since entering m_mode (saturating)
    int m_phase  = 0;   // clocks since the last tick, 0..PRESCALE-1
    int m_settle = 2;
    int m_drain  = 2;
    int m_maxon  = 0;

    function automatic int exp_valve();
        return (m_mode >= 1 && m_mode <= 4) ? 1 : 0;
    endfunction

    function automatic int exp_pump();
        return (m_mode == 3) ? 1 : 0;
    endfunction

    function automatic int exp_fault();
        return (m_mode == 5) ? 1 : 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        int v;
        case (a)
            5'h00:   v = exp_valve() + 2 * exp_pump() + 4 * m_mode + 32 * exp_fault();
            5'h04:   v = m_settle;
            5'h08:   v = m_drain;
            5'h0C:   v = m_maxon;
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    always @(posedge clk or negedge rst) begin
        int  nxt;
        bit  tk;
        if (!rst) begin
            m_mode = 0; m_ticks = 0; m_phase = 0;
            m_settle = 2; m_drain = 2; m_maxon = 0;
        end else begin
            tk  = (m_phase == PRESCALE - 1);
            nxt = m_mode;
            case (m_mode)
                0: nxt = cmd[1] ? 2 : (cmd[0] ? 1 : 0);
                1: nxt = cmd[1] ? 2 : (cmd[0] ? 1 : 0);
                2: if (!cmd[1]) nxt = cmd[0] ? 1 : 0;
                   else if (m_ticks >= m_settle) nxt = 3;
                3: if (WD && m_maxon != 0 && m_ticks >= m_maxon) nxt = 5;
                   else if (!cmd[1]) nxt = 4;
                4: if (m_ticks >= m_drain) nxt = cmd[1] ? 2 : (cmd[0] ? 1 : 0);
                5: if (cs && wr && addr == 5'h10 && d_in[0] && !cmd[1]) nxt = 0;
                default: nxt = 0;
            endcase
            if (cs && wr) begin
                if (addr == 5'h04) m_settle = int'(d_in[CNT_W-1:0]);
                if (addr == 5'h08) m_drain  = int'(d_in[CNT_W-1:0]);
                if (addr == 5'h0C && WD) m_maxon = int'(d_in[CNT_W-1:0]);
            end
            if (nxt != m_mode) m_ticks = 0;
            else if (tk && m_ticks < (1 << CNT_W) - 1) m_ticks++;
            m_phase = tk ? 0 : m_phase + 1;
            m_mode  = nxt;
        end
    end

    // ---------------------------------------------------------------- compare process
    logic prv_valve = 1'b0;
    logic prv_pump  = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                prv_valve = 1'b0;
                prv_pump  = 1'b0;
            end else begin
                chk("cmp_valve_en", {31'b0, valve_en}, 32'(exp_valve()));
                chk("cmp_pump_en",  {31'b0, pump_en},  32'(exp_pump()));
                chk("cmp_fault",    {31'b0, fault},    32'(exp_fault()));
                chk("cmp_d_out",    d_out,             model_read(addr));
                chk("cmp_mem_ready", {31'b0, mem_ready}, 32'd1);
                // Both drives may only move together when entering fault.
                if ((valve_en !== prv_valve) && (pump_en !== prv_pump)) begin
                    chk("cmp_joint_change_only_on_fault", {31'b0, fault}, 32'd1);
                end
                prv_valve = valve_en;
                prv_pump  = pump_en;
            end
        end
    end

    // ---------------------------------------------------------------- driver tasks
    task automatic set_cmd(input logic [1:0] v);
        @(negedge clk);
        cmd  = v;
        addr = 5'h00;
        rd   = 1'b1;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; d_in = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; addr = 5'h00; d_in = '0;
    endtask

    task automatic expect_here(input string name, input logic [31:0] exp);
        exp_q.push_back(exp);
        chk(name, d_out, exp_q.pop_front());
    endtask

    task automatic expect_read(input string name, input logic [4:0] a, input logic [31:0] exp);
        @(negedge clk);
        addr = a; cs = 1'b1; rd = 1'b1;
        @(posedge clk);
        #1;
        expect_here(name, exp);
        @(negedge clk);
        cs = 1'b0; addr = 5'h00;
    endtask

    function automatic logic pick(input int which);
        case (which)
            0:       return valve_en;
            1:       return pump_en;
            default: return fault;
        endcase
    endfunction

    // Counts clocks (sampled after each rising edge) until the chosen output
    // reaches val; an exhausted budget is a failed comparison.
    task automatic wait_out(input string name, input int which, input logic val,
                            input int budget, output int cycles);
        bit hit;
        cycles = 0;
        hit    = 1'b0;
        while (!hit && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
            hit = (pick(which) === val);
        end
        chk(name, {31'b0, hit}, 32'd1);
    endtask

    // A state with timer N lasts roughly N ticks; the tick phase relative to
    // state entry is arbitrary, so accept anything from just over N-1 ticks
    // up to N+1 ticks.
    task automatic chk_window(input string name, input int c, input int n);
        chk(name, 32'((c >= (n - 1) * PRESCALE + 1) && (c <= (n + 1) * PRESCALE)), 32'd1);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        int c;

        // Reset held low: all drives off, STATUS reads zero.
        #12;
        chk("rst_valve_en", {31'b0, valve_en}, 32'd0);
        chk("rst_pump_en",  {31'b0, pump_en},  32'd0);
        chk("rst_fault",    {31'b0, fault},    32'd0);
        chk("rst_status",   d_out,             32'h0000_0000);
        @(negedge clk);
        rst = 1'b1;
        expect_read("reset_status", 5'h00, 32'h0000_0000);
        expect_read("reset_settle", 5'h04, 32'd2);
        expect_read("reset_drain",  5'h08, 32'd2);
        expect_read("unmapped_rd",  5'h14, 32'd0);
        expect_read("ctrl_rd",      5'h10, 32'd0);

        // Normal cycle, SETTLE=3, DRAIN=2.
        bus_write(5'h04, 32'd3);
        bus_write(5'h08, 32'd2);
        expect_read("settle_rb", 5'h04, 32'd3);
        set_cmd(2'b10);
        wait_out("norm_valve_up", 0, 1'b1, 5, c);
        chk("norm_valve_latency", 32'(c), 32'd1);
        wait_out("norm_pump_up", 1, 1'b1, 30, c);
        chk_window("norm_settle_window", c, 3);
        set_cmd(2'b00);
        wait_out("norm_pump_down", 1, 1'b0, 5, c);
        chk("norm_pump_latency", 32'(c), 32'd1);
        wait_out("norm_valve_down", 0, 1'b0, 30, c);
        chk_window("norm_drain_window", c, 2);

        // Abort during settle: pump must never start, valve stays open.
        set_cmd(2'b10);
        repeat (3) @(negedge clk);
        set_cmd(2'b01);
        @(posedge clk);
        #1;
        expect_here("abort_status_valve", 32'h0000_0005);
        repeat (20) @(posedge clk);
        #1;
        expect_here("abort_status_hold", 32'h0000_0005);
        set_cmd(2'b00);
        wait_out("abort_idle", 0, 1'b0, 5, c);

        // Zero settle: pump follows valve by one clock. Then a short cmd drop
        // puts it in STOPPING; with the pump request back, drain expiry
        // returns to OPENING and straight on to RUNNING.
        bus_write(5'h04, 32'd0);
        set_cmd(2'b10);
        wait_out("zero_valve_up", 0, 1'b1, 5, c);
        wait_out("zero_pump_up", 1, 1'b1, 5, c);
        chk("zero_pump_latency", 32'(c), 32'd1);
        set_cmd(2'b00);
        @(posedge clk);
        #1;
        expect_here("stopping_status", 32'h0000_0011);
        set_cmd(2'b10);
        wait_out("restart_pump_up", 1, 1'b1, 20, c);
        expect_here("restart_status", 32'h0000_000F);
        set_cmd(2'b00);
        wait_out("restart_idle", 0, 1'b0, 30, c);

        // Watchdog, MAXON=5, SETTLE still 0.
        bus_write(5'h0C, 32'd5);
`ifdef ACT_SEQ_WATCHDOG_EN
        expect_read("maxon_rb", 5'h0C, 32'd5);
        set_cmd(2'b10);
        wait_out("wd_pump_up", 1, 1'b1, 5, c);
        wait_out("wd_fault_up", 2, 1'b1, 40, c);
        chk_window("wd_maxon_window", c, 5);
        chk("wd_valve_off", {31'b0, valve_en}, 32'd0);
        chk("wd_pump_off",  {31'b0, pump_en},  32'd0);
        expect_read("wd_status", 5'h00, 32'h0000_0034);
        bus_write(5'h10, 32'd1);
        expect_read("wd_clear_ignored", 5'h00, 32'h0000_0034);
        set_cmd(2'b00);
        expect_read("wd_sticky", 5'h00, 32'h0000_0034);
        bus_write(5'h10, 32'd1);
        expect_read("wd_cleared", 5'h00, 32'h0000_0000);
        chk("wd_fault_low", {31'b0, fault}, 32'd0);
`else
        expect_read("maxon_rb_off", 5'h0C, 32'd0);
        set_cmd(2'b10);
        wait_out("nowd_pump_up", 1, 1'b1, 5, c);
        repeat (40) @(posedge clk);
        #1;
        chk("nowd_fault", {31'b0, fault},   32'd0);
        chk("nowd_pump",  {31'b0, pump_en}, 32'd1);
        expect_read("nowd_status", 5'h00, 32'h0000_000F);
        bus_write(5'h10, 32'd1);
        expect_read("nowd_ctrl_ignored", 5'h00, 32'h0000_000F);
        set_cmd(2'b00);
        wait_out("nowd_idle", 0, 1'b0, 30, c);
`endif

        // Asynchronous reset in the middle of a pump run.
        set_cmd(2'b10);
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_valve", {31'b0, valve_en}, 32'd0);
        chk("async_rst_pump",  {31'b0, pump_en},  32'd0);
        cmd = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        expect_read("post_rst_settle", 5'h04, 32'd2);
        expect_read("post_rst_status", 5'h00, 32'h0000_0000);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                set_cmd(2'($urandom_range(0, 3)));
                repeat ($urandom_range(1, 12)) @(negedge clk);
            end else if (r <= 7) begin
                bus_write(5'(4 * $urandom_range(1, 3)), 32'($urandom_range(0, 5)));
            end else if (r == 8) begin
                bus_write(5'h10, 32'($urandom_range(0, 1)));
            end else begin
                @(negedge clk);
                addr = 5'($urandom_range(0, 31));
                rd   = 1'b1;
                repeat ($urandom_range(1, 4)) @(negedge clk);
            end
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Hard stop in case a wait above never returns.
    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation ran past 1000000 time units");
        $fatal(1, "simulation time limit exceeded");
    end

endmodule
